// File: rtl/qspi_phy_ctrl.sv
// qspi_phy_ctrl: byte-level SPI/dual/quad/octal PHY controller (SPI mode 0).
// Each accepted byte is shifted MSB first, L = 1/2/4/8 bits per SCLK period.
// The SCLK half-period is H = div_i+1 clk_i cycles. Chip select stays low
// across bytes until a byte flagged last_i, followed by HOLD and GAP phases.
// Optional macro QSPI_PHY_RX_DELAY_EN: data_i passes a 2-flop register and is
// sampled 2 cycles after each SCLK rising edge. The GAP phase is extended to
// match. This needs H >= 3.
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   div_i, cs_sel_i         divider and chip-select index, captured in IDLE
//   tx_valid_i/tx_ready_o   byte handshake; tx_data_i, mode_i, dir_i, last_i
//   rx_valid_o/rx_data_o    received byte, one-cycle pulse
//   sclk_o, cs_no           serial clock (idle low), active-low selects
//   data_o/data_i/data_oen_o pad out/in/tristate (oen high = input)
module qspi_phy_ctrl #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned NUM_CS = 1,
    parameter int unsigned DIV_W  = 8,
    localparam int unsigned CSW   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [DIV_W-1:0]  div_i,
    input  logic [CSW-1:0]    cs_sel_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    input  logic [7:0]        tx_data_i,
    input  logic [1:0]        mode_i,
    input  logic              dir_i,
    input  logic              last_i,
    output logic              rx_valid_o,
    output logic [7:0]        rx_data_o,
    output logic              sclk_o,
    output logic [NUM_CS-1:0] cs_no,
    output logic [LANES-1:0]  data_o,
    input  logic [LANES-1:0]  data_i,
    output logic [LANES-1:0]  data_oen_o
);

    localparam int unsigned CW = DIV_W + 1;
    localparam int unsigned LW = $clog2(LANES);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SHIFT_LO = 3'd1;
    localparam logic [2:0] S_SHIFT_HI = 3'd2;
    localparam logic [2:0] S_WAIT     = 3'd3;
    localparam logic [2:0] S_HOLD     = 3'd4;
    localparam logic [2:0] S_GAP      = 3'd5;

    logic [2:0]        st_q, st_d;
    logic [CW-1:0]     cnt_q, cnt_d, gap_end;
    logic [3:0]        bcnt_q, bcnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [1:0]        mode_q, mode_d, mode_eff;
    logic              dir_q, dir_d, last_q, last_d;
    logic [7:0]        txs_q, txs_d, rxs_q, rxs_d, rxd_q, rxd_d;
    logic              pend_q, pend_d, rxv_q, rxv_d, sclk_q, sclk_d, rdy_q, rdy_d;
    logic [NUM_CS-1:0] csn_q, csn_d;
    logic [LANES-1:0]  dout_q, dout_d, oen_q, oen_d, din_smp;
    logic              accept, phase_end, last_chunk, rx_en;
    int                lw;

`ifdef QSPI_PHY_RX_DELAY_EN
    logic [LANES-1:0]  din_q1, din_q2;
    logic [1:0]        stb_q, stb_d, stbl_q, stbl_d;
    assign din_smp = din_q2;
    assign gap_end = CW'(div_q) + CW'(2);
`else
    assign din_smp = data_i;
    assign gap_end = CW'(div_q);
`endif

    // Lane pattern for the current chunk; unused upper lanes idle high (WP#/HOLD#).
    function automatic logic [2*LANES-1:0] lane_pat(input logic [7:0] sh, input logic [1:0] m,
                                                    input logic wr);
        logic [LANES-1:0] d, t;
        int w;
        w = 1 << m;
        d = '1;
        t = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (m == 2'd0) begin
                if (i == 0) d[LW'(i)] = sh[7];
                if (i == 1) begin d[LW'(i)] = 1'b0; t[LW'(i)] = 1'b1; end
            end else if (i < w) begin
                if (wr) d[LW'(i)] = sh[3'(8 - w + i)];
                else begin d[LW'(i)] = 1'b0; t[LW'(i)] = 1'b1; end
            end
        end
        return {t, d};
    endfunction

    // Shift one sampled chunk into the receive register (single mode reads lane 1).
    function automatic logic [7:0] rx_shift(input logic [7:0] r, input logic [LANES-1:0] din,
                                            input logic [1:0] m);
        logic [7:0] d8;
        d8 = 8'(din);
        case (m)
            2'd0:    return {r[6:0], d8[1]};
            2'd1:    return {r[5:0], d8[1:0]};
            2'd2:    return {r[3:0], d8[3:0]};
            default: return d8;
        endcase
    endfunction

    // Next-state and registered-output logic.
    always_comb begin
        st_d   = st_q;   cnt_d  = cnt_q;  bcnt_d = bcnt_q; div_d  = div_q;
        mode_d = mode_q; dir_d  = dir_q;  last_d = last_q; txs_d  = txs_q;
        rxs_d  = rxs_q;  pend_d = pend_q; rxv_d  = 1'b0;   rxd_d  = rxd_q;
        sclk_d = sclk_q; csn_d  = csn_q;  accept = 1'b0;
`ifdef QSPI_PHY_RX_DELAY_EN
        stb_d  = {stb_q[0], 1'b0};
        stbl_d = {stbl_q[0], 1'b0};
`endif
        lw         = 1 << mode_q;
        last_chunk = (int'(bcnt_q) + lw) >= 8;
        phase_end  = (cnt_q == CW'(div_q));
        rx_en      = (mode_q == 2'd0) || !dir_q;
        mode_eff   = mode_i;
        if (LANES < 8 && mode_i == 2'd3) mode_eff = 2'd0;

        // Deliver a completed byte one cycle after its final sample.
        if (pend_q) begin
            rxv_d  = 1'b1;
            rxd_d  = rxs_q;
            pend_d = 1'b0;
        end

        case (st_q)
            S_IDLE: if (tx_valid_i) begin
                accept = 1'b1;
                div_d  = div_i;
                csn_d  = ~(NUM_CS'(1) << cs_sel_i);
            end
            S_WAIT: if (tx_valid_i) accept = 1'b1;
            S_SHIFT_LO: if (phase_end) begin
                cnt_d  = '0;
                sclk_d = 1'b1;
                st_d   = S_SHIFT_HI;
`ifdef QSPI_PHY_RX_DELAY_EN
                stb_d[0]  = 1'b1;
                stbl_d[0] = last_chunk && rx_en;
`else
                rxs_d = rx_shift(rxs_q, din_smp, mode_q);
                if (last_chunk && rx_en) pend_d = 1'b1;
`endif
            end else cnt_d = cnt_q + CW'(1);
            S_SHIFT_HI: if (phase_end) begin
                cnt_d  = '0;
                sclk_d = 1'b0;
                if (!last_chunk) begin
                    txs_d  = 8'(txs_q << lw);
                    bcnt_d = bcnt_q + 4'(lw);
                    st_d   = S_SHIFT_LO;
                end else st_d = last_q ? S_HOLD : S_WAIT;
            end else cnt_d = cnt_q + CW'(1);
            S_HOLD: if (phase_end) begin
                cnt_d = '0;
                csn_d = '1;
                st_d  = S_GAP;
            end else cnt_d = cnt_q + CW'(1);
            S_GAP: if (cnt_q == gap_end) begin
                cnt_d = '0;
                st_d  = S_IDLE;
            end else cnt_d = cnt_q + CW'(1);
            default: st_d = S_IDLE;
        endcase

`ifdef QSPI_PHY_RX_DELAY_EN
        if (stb_q[1]) rxs_d = rx_shift(rxs_q, din_smp, mode_q);
        if (stbl_q[1]) pend_d = 1'b1;
`endif

        // Per-byte capture; the first chunk appears on the pads with the accept.
        if (accept) begin
            mode_d = mode_eff;
            dir_d  = dir_i;
            last_d = last_i;
            txs_d  = tx_data_i;
            bcnt_d = '0;
            cnt_d  = '0;
            sclk_d = 1'b0;
            st_d   = S_SHIFT_LO;
        end

        rdy_d = (st_d == S_IDLE) || (st_d == S_WAIT);
        if (st_d inside {S_SHIFT_LO, S_SHIFT_HI, S_WAIT, S_HOLD}) begin
            {oen_d, dout_d} = lane_pat(txs_d, mode_d, dir_d);
        end else begin
            dout_d = '0;
            oen_d  = '1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            st_q   <= S_IDLE; cnt_q  <= '0;   bcnt_q <= '0;   div_q  <= '0;
            mode_q <= '0;     dir_q  <= 1'b0; last_q <= 1'b0; txs_q  <= '0;
            rxs_q  <= '0;     pend_q <= 1'b0; rxv_q  <= 1'b0; rxd_q  <= '0;
            sclk_q <= 1'b0;   csn_q  <= '1;   dout_q <= '0;   oen_q  <= '1;
            rdy_q  <= 1'b1;
        end else begin
            st_q   <= st_d;   cnt_q  <= cnt_d;  bcnt_q <= bcnt_d; div_q  <= div_d;
            mode_q <= mode_d; dir_q  <= dir_d;  last_q <= last_d; txs_q  <= txs_d;
            rxs_q  <= rxs_d;  pend_q <= pend_d; rxv_q  <= rxv_d;  rxd_q  <= rxd_d;
            sclk_q <= sclk_d; csn_q  <= csn_d;  dout_q <= dout_d; oen_q  <= oen_d;
            rdy_q  <= rdy_d;
        end
    end

`ifdef QSPI_PHY_RX_DELAY_EN
    // Input retiming pipeline and delayed sample strobes.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            din_q1 <= '0; din_q2 <= '0; stb_q <= '0; stbl_q <= '0;
        end else begin
            din_q1 <= data_i; din_q2 <= din_q1; stb_q <= stb_d; stbl_q <= stbl_d;
        end
    end
`endif

    // Ready is held low for as long as reset is asserted.
    assign tx_ready_o = rdy_q & ~reset_i;
    assign rx_valid_o = rxv_q;
    assign rx_data_o  = rxd_q;
    assign sclk_o     = sclk_q;
    assign cs_no      = csn_q;
    assign data_o     = dout_q;
    assign data_oen_o = oen_q;

endmodule

// File: tb/tb_qspi_phy_ctrl.sv
// tb_qspi_phy_ctrl: scoreboard bench for qspi_phy_ctrl (LANES=8, NUM_CS=4).
// Stimulus pushes expected received bytes; a monitor pops them on rx_valid_o.
module tb_qspi_phy_ctrl;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic [7:0] div_i = '0;
    logic [1:0] cs_sel_i = '0;
    logic       tx_valid_i = 1'b0;
    logic       tx_ready_o;
    logic [7:0] tx_data_i = '0;
    logic [1:0] mode_i = '0;
    logic       dir_i = 1'b0;
    logic       last_i = 1'b0;
    logic       rx_valid_o;
    logic [7:0] rx_data_o;
    logic       sclk_o;
    logic [3:0] cs_no;
    logic [7:0] data_o, data_i, data_oen_o;

    qspi_phy_ctrl #(.LANES(8), .NUM_CS(4), .DIV_W(8)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .div_i(div_i), .cs_sel_i(cs_sel_i),
        .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_data_i(tx_data_i),
        .mode_i(mode_i), .dir_i(dir_i), .last_i(last_i), .rx_valid_o(rx_valid_o),
        .rx_data_o(rx_data_o), .sclk_o(sclk_o), .cs_no(cs_no), .data_o(data_o),
        .data_i(data_i), .data_oen_o(data_oen_o)
    );

    always #5 clk_i = ~clk_i;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         cs_low_cyc = 0;
    int         cs_rise_cyc = 0;
    logic [3:0] cs_seen = '0;
    logic       cs_prev_low = 1'b0;
    logic [7:0] sb[$];
    logic [7:0] rec_d[$];
    logic [7:0] rec_o[$];

    // Device model: a bit stream shifted out after each SCLK rising edge.
    logic [31:0] dev_sh = '0;
    int          dev_l = 1;
    logic        dev_m0 = 1'b1;

    function automatic logic [7:0] dev_drive(input logic [31:0] s, input int l, input logic m0);
        logic [7:0] r;
        r = '0;
        if (m0) r[1] = s[31];
        else for (int i = 0; i < l; i++) r[3'(i)] = s[5'(32 - l + i)];
        return r;
    endfunction

    assign data_i = dev_drive(dev_sh, dev_l, dev_m0);

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(posedge sclk_o) begin
        #1;
        rec_d.push_back(data_o);
        rec_o.push_back(data_oen_o);
        dev_sh = dev_sh << dev_l;
    end

    // Chip-select activity monitor.
    always @(negedge clk_i) begin
        if (cs_no != 4'hF) begin
            cs_low_cyc++;
            cs_seen = cs_seen | ~cs_no;
        end else if (cs_prev_low) begin
            cs_rise_cyc = cyc;
        end
        cs_prev_low = (cs_no != 4'hF);
    end

    // Scoreboard monitor for received bytes.
    always @(negedge clk_i) begin
        if (rx_valid_o === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected actual=%02h required=none", rx_data_o);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                if (rx_data_o !== e) begin
                    errors++;
                    $display("FAIL rx_data actual=%02h required=%02h", rx_data_o, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_dev(input logic [31:0] s, input int l, input logic m0);
        dev_sh = s;
        dev_l  = l;
        dev_m0 = m0;
        rec_d.delete();
        rec_o.delete();
        cs_low_cyc = 0;
        cs_seen = '0;
    endtask

    // Offer a byte; returns #1 after the accepting edge with valid dropped.
    task automatic send(input logic [7:0] d, input logic [1:0] m, input logic wr,
                        input logic lst);
        logic acc;
        acc = 1'b0;
        tx_valid_i = 1'b1; tx_data_i = d; mode_i = m; dir_i = wr; last_i = lst;
        for (int k = 0; k < 4000 && !acc; k++) begin
            @(negedge clk_i);
            if (tx_ready_o) begin acc = 1'b1; acc_cyc = cyc + 1; end
            @(posedge clk_i);
        end
        #1 tx_valid_i = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=no_accept required=accept");
        end
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 4000 && !done; k++) begin
            @(negedge clk_i);
            if (tx_ready_o && cs_no == 4'hF) done = 1'b1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int a0, a1, a2;
        logic ok;

        // Reset values while reset is held.
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_sclk", sclk_o, 0);
        chk("rst_cs", cs_no, 4'hF);
        chk("rst_dout", data_o, 0);
        chk("rst_oen", data_oen_o, 8'hFF);
        chk("rst_rxv", rx_valid_o, 0);
        chk("rst_rxd", rx_data_o, 0);
        chk("rst_ready", tx_ready_o, 0);
        @(posedge clk_i);
        #1 reset_i = 1'b0;
        @(negedge clk_i);
        chk("ready_after_rst", tx_ready_o, 1);
        @(posedge clk_i);
        #1;

        // Single mode, H=2, full duplex 0xA5 out, 0x3C in on lane 1.
        div_i = 8'd1; cs_sel_i = 2'd0;
        set_dev(32'h3C00_0000, 1, 1'b1);
        sb.push_back(8'h3C);
        send(8'hA5, 2'd0, 1'b1, 1'b1);
        wait_idle();
        chk("m0_rises", rec_d.size(), 8);
        begin
            logic [7:0] b;
            b = '0;
            for (int i = 0; i < 8 && i < rec_d.size(); i++) b = {b[6:0], rec_d[i][0]};
            chk("m0_lane0_bits", b, 8'hA5);
        end
        // 8 periods of 2H plus HOLD of H.
        chk("m0_cs_low_cycles", cs_low_cyc, 34);
        chk("m0_cs_mask", cs_seen, 4'b0001);

        // Quad read, H=1, device drives 0x3 then 0xC.
        div_i = 8'd0; cs_sel_i = 2'd1;
        set_dev(32'h3C00_0000, 4, 1'b0);
        sb.push_back(8'h3C);
        send(8'h00, 2'd2, 1'b0, 1'b1);
        wait_idle();
        chk("m2_rises", rec_d.size(), 2);
        chk("m2_oen_low_lanes", rec_o[0][3:0], 4'hF);
        chk("m2_oen_high_lanes", rec_o[0][7:4], 4'h0);
        chk("m2_dout_high_lanes", rec_d[0][7:4], 4'hF);
        chk("m2_cs_low_cycles", cs_low_cyc, 5);

        // Three back-to-back single-mode bytes with valid held.
        cs_sel_i = 2'd0;
        set_dev(32'h1122_3300, 1, 1'b1);
        sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h33);
        send(8'h01, 2'd0, 1'b1, 1'b0); a0 = acc_cyc;
        send(8'h02, 2'd0, 1'b1, 1'b0); a1 = acc_cyc;
        send(8'h03, 2'd0, 1'b1, 1'b1); a2 = acc_cyc;
        wait_idle();
        chk("b2b_spacing_1", a1 - a0, 17);
        chk("b2b_spacing_2", a2 - a1, 17);
        chk("b2b_rises", rec_d.size(), 24);

        // Late second byte: WAIT holds CS low with SCLK low.
        set_dev(32'h0, 4, 1'b0);
        send(8'h5A, 2'd2, 1'b1, 1'b0);
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk_i);
            if (tx_ready_o) ok = 1'b1;
        end
        for (int k = 0; k < 5; k++) begin
            if (!(tx_ready_o && cs_no == 4'hE && !sclk_o)) ok = 1'b0;
            @(negedge clk_i);
        end
        chk("late_wait_hold", ok, 1);
        @(posedge clk_i);
        #1;
        send(8'hC3, 2'd2, 1'b1, 1'b1);
        wait_idle();
        chk("late_second_byte", {rec_d[2][3:0], rec_d[3][3:0]}, 8'hC3);

        // Octal write 0x81: one SCLK period.
        set_dev(32'h0, 8, 1'b0);
        send(8'h81, 2'd3, 1'b1, 1'b1);
        wait_idle();
        chk("m3_rises", rec_d.size(), 1);
        chk("m3_dout", rec_d[0], 8'h81);
        chk("m3_oen", rec_o[0], 8'h00);

        // Reset mid-byte: immediate reset values, no rx, accept right after release.
        div_i = 8'd3; cs_sel_i = 2'd1;
        set_dev(32'hFFFF_FFFF, 1, 1'b1);
        send(8'hFF, 2'd0, 1'b1, 1'b1);
        repeat (20) @(posedge clk_i);
        #1 reset_i = 1'b1;
        #1;
        chk("abort_sclk", sclk_o, 0);
        chk("abort_cs", cs_no, 4'hF);
        chk("abort_dout", data_o, 0);
        chk("abort_oen", data_oen_o, 8'hFF);
        chk("abort_rxv", rx_valid_o, 0);
        chk("abort_ready", tx_ready_o, 0);
        repeat (3) @(posedge clk_i);
        #1 reset_i = 1'b0;
        a0 = cyc;
        div_i = 8'd0;
        send(8'h00, 2'd2, 1'b1, 1'b1);
        chk("post_rst_accept", acc_cyc - a0, 1);
        @(negedge clk_i);
        chk("post_rst_cs", cs_no, 4'b1101);
        wait_idle();

        // CS index 2, H=3, then next byte waits out the GAP.
        div_i = 8'd2; cs_sel_i = 2'd2;
        set_dev(32'h0, 4, 1'b0);
        send(8'hF0, 2'd2, 1'b1, 1'b1);
        send(8'h0F, 2'd2, 1'b1, 1'b1);
        chk("cs2_low_cycles", cs_low_cyc, 15);
        chk("cs2_gap_to_accept", acc_cyc - cs_rise_cyc, 4);
        wait_idle();
        chk("cs2_mask", cs_seen, 4'b0100);

        repeat (10) @(posedge clk_i);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
